// File: rtl/ysyx_22051145_pkg.sv
// rtl/ysyx_22051145_pkg.sv - shared constants and types for the ID/EX stage
// Purpose: ALU mode encodings, buffer state encoding, default datapath width
//          and the illegal-mode predicate used by the ID/EX buffer.
// Ports:   none (package).
package ysyx_22051145_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [3:0] MODE_LUI   = 4'd0;
  localparam logic [3:0] MODE_AUIPC = 4'd1;
  localparam logic [3:0] MODE_ADD   = 4'd2;
  localparam logic [3:0] MODE_SUB   = 4'd3;
  localparam logic [3:0] MODE_SLL   = 4'd4;
  localparam logic [3:0] MODE_SLT   = 4'd5;
  localparam logic [3:0] MODE_SLTU  = 4'd6;
  localparam logic [3:0] MODE_XOR   = 4'd7;
  localparam logic [3:0] MODE_SRL   = 4'd8;
  localparam logic [3:0] MODE_SRA   = 4'd9;
  localparam logic [3:0] MODE_OR    = 4'd10;
  localparam logic [3:0] MODE_AND   = 4'd11;

  // Number of valid buffered entries: head only in ONE, head + skid in TWO.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Encodings above the last defined ALU mode have no meaning to the ALU.
  function automatic logic mode_illegal(input logic [3:0] mode);
    return mode > MODE_AND;
  endfunction

endpackage

// File: rtl/ysyx_22051145_opsel.sv
// rtl/ysyx_22051145_opsel.sv - combinational ALU operand selection
// Purpose: builds op1/op2 from decode outputs before they are buffered.
// Ports:   rs1, rs2, imm  - register operands and sign-extended immediate
//          op2_imm        - 1 selects imm as op2, 0 selects rs2
//          mode           - ALU mode; LUI forces op1 to zero
//          op1, op2       - selected operands
module ysyx_22051145_opsel
  import ysyx_22051145_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic            op2_imm,
  input  logic [3:0]      mode,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2
);

  // LUI computes 0 + imm in the ALU, so rs1 must not leak in.
  assign op1 = (mode == MODE_LUI) ? '0 : rs1;
  assign op2 = op2_imm ? imm : rs2;

endmodule

// File: rtl/ysyx_22051145_id_ex.sv
// rtl/ysyx_22051145_id_ex.sv - ID/EX pipeline buffer with skid entry
// Purpose: selects ALU operands and holds up to two decoded instructions
//          (head + skid) between decode and the ALU with valid/ready flow.
// Ports:   clk, rst_n            - clock, asynchronous active-low reset
//          flush                 - drop every buffered and offered entry
//          in_valid/in_ready     - decode handshake (in_ready registered)
//          in_pc..in_wen         - decoded instruction fields
//          out_valid/out_ready   - ALU handshake (out_valid is ALU enable)
//          out_pc..out_wen       - head entry fields, zero when not valid
//          out_illegal           - head entry carries an undefined mode
module ysyx_22051145_id_ex
  import ysyx_22051145_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_op2_imm,
  input  logic [3:0]      in_mode,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [3:0]      out_mode,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_illegal
);

  // Entry layout: {pc, op1, op2, mode, rd, wen}
  localparam int EW = 3 * XLEN + 10;

  state_e         state_q, state_d;
  logic [EW-1:0]  head_q, head_d;
  logic [EW-1:0]  skid_q, skid_d;

  logic [XLEN-1:0] sel_op1, sel_op2;
  logic [EW-1:0]   in_entry;
  logic [EW-1:0]   head_vis;
  logic            in_xfer, out_xfer;
  logic            head_wen;

  ysyx_22051145_opsel #(.XLEN(XLEN)) u_opsel (
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .op2_imm (in_op2_imm),
    .mode    (in_mode),
    .op1     (sel_op1),
    .op2     (sel_op2)
  );

  assign in_entry = {in_pc, sel_op1, sel_op2, in_mode, in_rd, in_wen};

  // Both handshake flags come straight from the state flop, so in_ready
  // never depends combinationally on out_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            head_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_d  = in_entry;
            state_d = ST_TWO;
          end else if (in_xfer && out_xfer) begin
            head_d  = in_entry;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Gate on out_valid so stale head contents never show and an async reset
  // zeroes the outputs without waiting for a clock.
  assign head_vis = out_valid ? head_q : '0;
  assign {out_pc, out_op1, out_op2, out_mode, out_rd, head_wen} = head_vis;
  assign out_illegal = out_valid & mode_illegal(out_mode);
  assign out_wen     = head_wen & ~out_illegal;

endmodule

// File: tb/tb_ysyx_22051145_id_ex.sv
// tb/tb_ysyx_22051145_id_ex.sv - directed self-checking bench for the ID/EX buffer
module tb_ysyx_22051145_id_ex;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_pc = '0;
  logic [XLEN-1:0] in_rs1 = '0;
  logic [XLEN-1:0] in_rs2 = '0;
  logic [XLEN-1:0] in_imm = '0;
  logic            in_op2_imm = 1'b0;
  logic [3:0]      in_mode = 4'd0;
  logic [4:0]      in_rd = 5'd0;
  logic            in_wen = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [3:0]      out_mode;
  logic [4:0]      out_rd;
  logic            out_wen;
  logic            out_illegal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ysyx_22051145_id_ex #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .in_op2_imm  (in_op2_imm),
    .in_mode     (in_mode),
    .in_rd       (in_rd),
    .in_wen      (in_wen),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_op1     (out_op1),
    .out_op2     (out_op2),
    .out_mode    (out_mode),
    .out_rd      (out_rd),
    .out_wen     (out_wen),
    .out_illegal (out_illegal)
  );

  task automatic offer(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rs1,
                       input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] imm,
                       input logic op2_imm, input logic [3:0] mode,
                       input logic [4:0] rd, input logic wen);
    in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_op2_imm = op2_imm; in_mode = mode; in_rd = rd; in_wen = wen;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    tests++; if (out_pc !== 64'h0 || out_op1 !== 64'h0 || out_illegal !== 1'b0) begin
      fails++; $display("FAIL reset_data: pc %0h op1 %0h ill %0b want 0", out_pc, out_op1, out_illegal); end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_op();
    out_ready = 1'b1;
    offer(64'h100, 64'd5, 64'd7, 64'h999, 1'b0, 4'd2, 5'd3, 1'b1);
    step(); idle();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    tests++; if (out_op1 !== 64'd5 || out_op2 !== 64'd7) begin
      fails++; $display("FAIL single_ops: got %0h/%0h want 5/7", out_op1, out_op2); end
    tests++; if (out_mode !== 4'd2 || out_pc !== 64'h100 || out_rd !== 5'd3 || out_wen !== 1'b1) begin
      fails++; $display("FAIL single_fields: mode %0d pc %0h rd %0d wen %0b want 2 100 3 1", out_mode, out_pc, out_rd, out_wen); end
    step();
    tests++; if (out_valid !== 1'b0 || out_op1 !== 64'h0) begin
      fails++; $display("FAIL single_drain: valid %0b op1 %0h want 0 0", out_valid, out_op1); end
  endtask

  task automatic test_lui();
    out_ready = 1'b1;
    offer(64'h104, 64'hFFFF, 64'h77, 64'h12345000, 1'b1, 4'd0, 5'd4, 1'b1);
    step(); idle();
    tests++; if (out_op1 !== 64'h0 || out_op2 !== 64'h12345000 || out_mode !== 4'd0) begin
      fails++; $display("FAIL lui: op1 %0h op2 %0h mode %0d want 0 12345000 0", out_op1, out_op2, out_mode); end
    step();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    offer(64'h108, 64'h1, 64'h2, 64'h0, 1'b0, 4'd13, 5'd5, 1'b1);
    step(); idle();
    tests++; if (out_illegal !== 1'b1 || out_wen !== 1'b0 || out_mode !== 4'd13) begin
      fails++; $display("FAIL illegal: ill %0b wen %0b mode %0d want 1 0 13", out_illegal, out_wen, out_mode); end
    step();
    tests++; if (out_valid !== 1'b0 || out_illegal !== 1'b0) begin
      fails++; $display("FAIL illegal_drain: valid %0b ill %0b want 0 0", out_valid, out_illegal); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(64'hA0, 64'h11, 64'h0, 64'h0, 1'b0, 4'd2, 5'd1, 1'b1);
    step();
    tests++; if (in_ready !== 1'b1 || out_op1 !== 64'h11) begin
      fails++; $display("FAIL bp_a: ready %0b op1 %0h want 1 11", in_ready, out_op1); end
    offer(64'hB0, 64'h22, 64'h0, 64'h0, 1'b0, 4'd2, 5'd1, 1'b1);
    step();
    tests++; if (in_ready !== 1'b0 || out_op1 !== 64'h11) begin
      fails++; $display("FAIL bp_full: ready %0b op1 %0h want 0 11", in_ready, out_op1); end
    offer(64'hC0, 64'h33, 64'h0, 64'h0, 1'b0, 4'd2, 5'd1, 1'b1);
    step();
    tests++; if (in_ready !== 1'b0 || out_op1 !== 64'h11 || out_pc !== 64'hA0) begin
      fails++; $display("FAIL bp_hold: ready %0b op1 %0h pc %0h want 0 11 a0", in_ready, out_op1, out_pc); end
    out_ready = 1'b1;
    step();
    tests++; if (out_op1 !== 64'h22 || out_pc !== 64'hB0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_b: op1 %0h pc %0h ready %0b want 22 b0 1", out_op1, out_pc, in_ready); end
    step(); idle();
    tests++; if (out_op1 !== 64'h33 || out_pc !== 64'hC0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL bp_c: op1 %0h pc %0h valid %0b want 33 c0 1", out_op1, out_pc, out_valid); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_end: valid %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] e1, e2;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(64'h200 + 64'(i * 4), 64'h40 + 64'(i), 64'h80 + 64'(i), 64'h0, 1'b0, 4'd3, 5'd9, 1'b1);
      step();
      e1 = 64'h40 + 64'(i);
      e2 = 64'h80 + 64'(i);
      tests++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_op1 !== e1 || out_op2 !== e2) begin
        fails++; $display("FAIL b2b_%0d: valid %0b ready %0b op1 %0h op2 %0h want 1 1 %0h %0h",
                          i, out_valid, in_ready, out_op1, out_op2, e1, e2); end
    end
    idle(); step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end: valid %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(64'hD0, 64'hD, 64'h0, 64'h0, 1'b0, 4'd2, 5'd1, 1'b1); step();
    offer(64'hE0, 64'hE, 64'h0, 64'h0, 1'b0, 4'd2, 5'd1, 1'b1); step();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_pre: ready %0b want 0", in_ready); end
    offer(64'hF0, 64'hF, 64'h0, 64'h0, 1'b0, 4'd2, 5'd1, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0; idle(); out_ready = 1'b1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_op1 !== 64'h0) begin
      fails++; $display("FAIL flush_state: valid %0b ready %0b op1 %0h want 0 1 0", out_valid, in_ready, out_op1); end
    for (int i = 0; i < 2; i++) begin
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost_%0d: valid %0b want 0", i, out_valid); end
    end
    offer(64'h1F0, 64'h5A, 64'h0, 64'h0, 1'b0, 4'd2, 5'd1, 1'b1); step(); idle();
    tests++; if (out_valid !== 1'b1 || out_op1 !== 64'h5A) begin
      fails++; $display("FAIL flush_after: valid %0b op1 %0h want 1 5a", out_valid, out_op1); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    offer(64'h300, 64'h61, 64'h0, 64'h0, 1'b0, 4'd2, 5'd1, 1'b1); step();
    offer(64'h304, 64'h62, 64'h0, 64'h0, 1'b0, 4'd2, 5'd1, 1'b1); step();
    idle();
    rst_n = 1'b0;
    #2;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_flags: valid %0b ready %0b want 0 1", out_valid, in_ready); end
    tests++; if (out_op1 !== 64'h0 || out_pc !== 64'h0 || out_mode !== 4'd0 || out_wen !== 1'b0) begin
      fails++; $display("FAIL rstmid_data: op1 %0h pc %0h mode %0d wen %0b want 0", out_op1, out_pc, out_mode, out_wen); end
    @(negedge clk); rst_n = 1'b1;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_empty: valid %0b want 0", out_valid); end
    out_ready = 1'b1;
    offer(64'h308, 64'h63, 64'h64, 64'h0, 1'b0, 4'd7, 5'd2, 1'b1); step(); idle();
    tests++; if (out_valid !== 1'b1 || out_op1 !== 64'h63 || out_op2 !== 64'h64 || out_mode !== 4'd7) begin
      fails++; $display("FAIL rstmid_restart: valid %0b op1 %0h op2 %0h mode %0d want 1 63 64 7",
                        out_valid, out_op1, out_op2, out_mode); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_end: valid %0b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_lui();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ysyx_22051145_id_ex.md
YSYX_22051145_ID_EX -- requirements
Module: ysyx_22051145_id_ex

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Parameter XLEN SHALL default to 64 and set the operand and pc width.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 flush  in  1  discards all buffered entries; dominates every other input.
REQ-006 in_valid  in  1  decode offers an instruction.
REQ-007 in_ready  out  1  block can accept the offer; registered.
REQ-008 in_pc  in  XLEN  instruction pc.
REQ-009 in_rs1, in_rs2, in_imm  in  XLEN each  register-file operands and sign-extended immediate.
REQ-010 in_op2_imm  in  1  1 selects in_imm as op2, 0 selects in_rs2.
REQ-011 in_mode  in  4  ALU mode, 0..11 as defined in the package.
REQ-012 in_rd  in  5  destination register; in_wen  in  1  write-back enable.
REQ-013 out_valid  out  1  head entry valid; also drives ALU en.
REQ-014 out_ready  in  1  ALU stage consumes the head entry.
REQ-015 out_pc, out_op1, out_op2  out  XLEN each; out_mode  out  4; out_rd  out  5; out_wen  out  1.
REQ-016 out_illegal  out  1  head entry carried a mode of 12..15.

Function
REQ-017 Transfer in SHALL occur on a rising edge with in_valid&in_ready; transfer out SHALL occur on a rising edge with out_valid&out_ready.
REQ-018 Operand selection SHALL happen before capture: op1=in_rs1; op2=in_op2_imm?in_imm:in_rs2; for mode 0 (LUI) op1 SHALL be forced to 0.
REQ-019 Storage SHALL be a 2-entry buffer (head + skid) with states EMPTY, ONE, TWO.
REQ-020 EMPTY: an in-transfer -> ONE; no in-transfer -> stay.
REQ-021 ONE: in-transfer without out-transfer -> TWO (new entry to skid); out-transfer without in-transfer -> EMPTY; both -> stay ONE with the new entry in head.
REQ-022 TWO: out-transfer -> ONE, skid moves to head; no out-transfer -> stay; in_ready is 0, so no in-transfer can occur.
REQ-023 in_ready SHALL be 1 exactly when state != TWO, registered, never combinationally dependent on out_ready.
REQ-024 out_valid SHALL be 1 exactly when state != EMPTY; head outputs SHALL hold stable while out_valid&!out_ready.
REQ-025 Latency in->out SHALL be one cycle when empty; full throughput (one per cycle) SHALL be sustained while out_ready=1.
REQ-026 Order SHALL be preserved: entries leave in acceptance order.
REQ-027 flush=1 SHALL force state EMPTY at the next edge, dropping head, skid and any concurrent input; in_ready SHALL read 1 the following cycle.
REQ-028 Mode 12..15 SHALL be captured unmodified, with out_illegal=1 and out_wen forced to 0 for that entry.
REQ-029 While out_valid=0 the data outputs SHALL be 0.

Reset
REQ-030 rst_n low SHALL asynchronously set state EMPTY, out_valid 0, in_ready 1, all data outputs and out_illegal 0.
REQ-031 Reset asserted mid-transfer SHALL discard both entries; the first post-reset edge SHALL behave as EMPTY.
REQ-032 Reset deassertion SHALL be synchronised by the integrator; the block assumes release away from the clock edge.

Structure
REQ-033 Package ysyx_22051145_pkg SHALL hold the ALU mode constants (LUI=0, AUIPC=1, ADD=2, SUB=3, SLL=4, SLT=5, SLTU=6, XOR=7, SRL=8, SRA=9, OR=10, AND=11), the state encoding, and the XLEN default.
REQ-034 The operand mux SHALL be the single sub-module ysyx_22051145_opsel (combinational); buffer and FSM stay in the top.

Verification
REQ-035 Single op: in ADD, rs1=5, rs2=7, op2_imm=0, out_ready=1 -> next cycle out_valid=1, op1=5, op2=7, mode=2, then out_valid=0.
REQ-036 Backpressure: out_ready=0, three back-to-back offers A,B,C -> A,B accepted, in_ready=0 after B, C held; release out_ready -> A,B,C emerge in order, no loss or duplicate.
REQ-037 LUI with imm=0x12345000, rs1=0xFFFF -> op1=0, op2=0x12345000, mode=0.
REQ-038 Flush in state TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped entries never appear.
REQ-039 Mode 13, wen=1 -> out_illegal=1, out_wen=0, out_mode=13.
REQ-040 rst_n low mid-stream with out_ready=0 -> outputs zero immediately, no clock required; stream restarts cleanly after release.
